microcode_sequencer: RTL and testbench

MICROCODE_SEQUENCER -- requirements
Module: microcode_sequencer

---
 rtl/microcode_sequencer.sv | 144 ++++++++++++++
 tb/tb_microcode_sequencer.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/microcode_sequencer.sv
// Microcode sequencer: streams a boot image into the microcode store, then walks
// microcode at {opcode, uop_count} and decodes each word into datapath controls.
module microcode_sequencer #(
    parameter int          BOOT_ENABLE = 1,
    parameter logic [11:0] BOOT_LAST   = 12'd4095
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        BOOT_VALID,
    input  logic [7:0]  BOOT_BYTE,
    output logic        BOOT_READY,
    output logic [11:0] BOOTSTRAP_ADDR,
    output logic [7:0]  BOOTSTRAP_DATA,
    output logic        BOOTSTRAP_N_WE,
    output logic        N_BOOTED,
    output logic [10:0] MC_ADDR,
    input  logic [31:0] MC_WORD,
    input  logic [31:0] OPWORD,
    input  logic        STALL,
    output logic [5:0]  CTRL_DATA,
    output logic [1:0]  REG_SEL,
    output logic [2:0]  OUT_PLANE,
    output logic [2:0]  IN_PLANE,
    output logic        MISC,
    output logic [3:0]  MISC2
);

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_WRITE = 2'd1,
        ST_RUN   = 2'd2
    } state_e;

    // Layout of the low 19 bits of a microcode word; bits [31:19] are unused.
    typedef struct packed {
        logic [3:0] misc2;
        logic       misc;
        logic [2:0] in_plane;
        logic [2:0] out_plane;
        logic [1:0] reg_sel;
        logic [5:0] ctrl_data;
    } uop_fields_t;

    localparam state_e     RESET_STATE   = (BOOT_ENABLE != 0) ? ST_LOAD : ST_RUN;
    localparam logic       RESET_BOOTED  = (BOOT_ENABLE != 0) ? 1'b1 : 1'b0;
    localparam logic [2:0] IN_PLANE_OPLD = 3'd6;

    state_e      state_q, state_d;
    logic [11:0] boot_addr_q, boot_addr_d;
    logic [7:0]  boot_data_q, boot_data_d;
    logic        n_booted_q, n_booted_d;
    logic [5:0]  opcode_q, opcode_d;
    logic [4:0]  uop_count_q, uop_count_d;

    uop_fields_t raw_fields;
    uop_fields_t out_fields;
    logic        run_active;

    assign raw_fields = uop_fields_t'(MC_WORD[18:0]);
    assign run_active = (state_q == ST_RUN) && !STALL;

    // NOTE: every always_comb target gets a default first, so no path infers a latch.
    always_comb begin
        state_d     = state_q;
        boot_addr_d = boot_addr_q;
        boot_data_d = boot_data_q;
        opcode_d    = opcode_q;
        uop_count_d = uop_count_q;

        case (state_q)
            ST_LOAD: begin
                opcode_d    = '0;
                uop_count_d = '0;
                if (BOOT_VALID) begin
                    boot_data_d = BOOT_BYTE;
                    state_d     = ST_WRITE;
                end
            end
            ST_WRITE: begin
                opcode_d    = '0;
                uop_count_d = '0;
                if (boot_addr_q == BOOT_LAST) begin
                    state_d = ST_RUN;
                end else begin
                    boot_addr_d = boot_addr_q + 12'd1;
                    state_d     = ST_LOAD;
                end
            end
            ST_RUN: begin
                if (!STALL) begin
                    // Counter reset and opcode load are independent; both may fire together.
                    uop_count_d = raw_fields.misc ? 5'd0 : uop_count_q + 5'd1;
                    if (raw_fields.in_plane == IN_PLANE_OPLD) begin
                        opcode_d = raw_fields.misc2[0] ? raw_fields.ctrl_data : OPWORD[31:26];
                    end
                end
            end
            default: begin
                state_d     = RESET_STATE;
                opcode_d    = '0;
                uop_count_d = '0;
            end
        endcase

        n_booted_d = (state_d != ST_RUN);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= RESET_STATE;
            boot_addr_q <= '0;
            boot_data_q <= '0;
            n_booted_q  <= RESET_BOOTED;
            opcode_q    <= '0;
            uop_count_q <= '0;
        end else begin
            state_q     <= state_d;
            boot_addr_q <= boot_addr_d;
            boot_data_q <= boot_data_d;
            n_booted_q  <= n_booted_d;
            opcode_q    <= opcode_d;
            uop_count_q <= uop_count_d;
        end
    end

    // Stalled or not running: zero every control so no datapath write is repeated.
    assign out_fields = run_active ? raw_fields : '0;

    assign CTRL_DATA = out_fields.ctrl_data;
    assign REG_SEL   = out_fields.reg_sel;
    assign OUT_PLANE = out_fields.out_plane;
    assign IN_PLANE  = out_fields.in_plane;
    assign MISC      = out_fields.misc;
    assign MISC2     = out_fields.misc2;

    assign BOOT_READY     = (state_q == ST_LOAD);
    assign BOOTSTRAP_N_WE = (state_q != ST_WRITE);
    assign BOOTSTRAP_ADDR = boot_addr_q;
    assign BOOTSTRAP_DATA = boot_data_q;
    assign N_BOOTED       = n_booted_q;
    assign MC_ADDR        = {opcode_q, uop_count_q};

endmodule

// File: tb/tb_microcode_sequencer.sv
// Directed bench for microcode_sequencer with a 4-byte boot image (BOOT_LAST=3).
module tb_microcode_sequencer;

    logic        CLK = 1'b0;
    logic        RST;
    logic        BOOT_VALID;
    logic [7:0]  BOOT_BYTE;
    logic        BOOT_READY;
    logic [11:0] BOOTSTRAP_ADDR;
    logic [7:0]  BOOTSTRAP_DATA;
    logic        BOOTSTRAP_N_WE;
    logic        N_BOOTED;
    logic [10:0] MC_ADDR;
    logic [31:0] MC_WORD;
    logic [31:0] OPWORD;
    logic        STALL;
    logic [5:0]  CTRL_DATA;
    logic [1:0]  REG_SEL;
    logic [2:0]  OUT_PLANE;
    logic [2:0]  IN_PLANE;
    logic        MISC;
    logic [3:0]  MISC2;

    int n_checks = 0;
    int n_fail   = 0;

    microcode_sequencer #(
        .BOOT_ENABLE(1),
        .BOOT_LAST  (12'd3)
    ) dut (
        .CLK           (CLK),
        .RST           (RST),
        .BOOT_VALID    (BOOT_VALID),
        .BOOT_BYTE     (BOOT_BYTE),
        .BOOT_READY    (BOOT_READY),
        .BOOTSTRAP_ADDR(BOOTSTRAP_ADDR),
        .BOOTSTRAP_DATA(BOOTSTRAP_DATA),
        .BOOTSTRAP_N_WE(BOOTSTRAP_N_WE),
        .N_BOOTED      (N_BOOTED),
        .MC_ADDR       (MC_ADDR),
        .MC_WORD       (MC_WORD),
        .OPWORD        (OPWORD),
        .STALL         (STALL),
        .CTRL_DATA     (CTRL_DATA),
        .REG_SEL       (REG_SEL),
        .OUT_PLANE     (OUT_PLANE),
        .IN_PLANE      (IN_PLANE),
        .MISC          (MISC),
        .MISC2         (MISC2)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    function automatic logic [31:0] mkword(input logic [5:0] c, input logic [1:0] r,
                                           input logic [2:0] o, input logic [2:0] i,
                                           input logic m, input logic [3:0] m2);
        return {13'h0, m2, m, i, o, r, c};
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] boot_bytes [4];
        boot_bytes = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};

        RST        = 1'b1;
        BOOT_VALID = 1'b0;
        BOOT_BYTE  = 8'h00;
        MC_WORD    = 32'h0;
        OPWORD     = 32'h0;
        STALL      = 1'b0;
        tick();
        tick();

        check("rst_addr",     32'(BOOTSTRAP_ADDR), 32'h0);
        check("rst_data",     32'(BOOTSTRAP_DATA), 32'h0);
        check("rst_nwe",      32'(BOOTSTRAP_N_WE), 32'h1);
        check("rst_nbooted",  32'(N_BOOTED),       32'h1);
        check("rst_mcaddr",   32'(MC_ADDR),        32'h0);
        check("rst_ready",    32'(BOOT_READY),     32'h1);

        // Boot with BOOT_VALID held high: one strobe every two cycles.
        RST        = 1'b0;
        BOOT_VALID = 1'b1;
        for (int i = 0; i < 4; i++) begin
            BOOT_BYTE = boot_bytes[i];
            tick();
            check("boot_we_nwe",     32'(BOOTSTRAP_N_WE), 32'h0);
            check("boot_we_addr",    32'(BOOTSTRAP_ADDR), 32'(i));
            check("boot_we_data",    32'(BOOTSTRAP_DATA), 32'(boot_bytes[i]));
            check("boot_we_ready",   32'(BOOT_READY),     32'h0);
            check("boot_we_nbooted", 32'(N_BOOTED),       32'h1);
            BOOT_BYTE = 8'h5A;
            tick();
            if (i < 3) begin
                check("boot_ld_nwe",   32'(BOOTSTRAP_N_WE), 32'h1);
                check("boot_ld_addr",  32'(BOOTSTRAP_ADDR), 32'(i + 1));
                check("boot_ld_ready", 32'(BOOT_READY),     32'h1);
            end else begin
                check("run_nbooted", 32'(N_BOOTED),       32'h0);
                check("run_mcaddr0", 32'(MC_ADDR),        32'h0);
                check("run_ready",   32'(BOOT_READY),     32'h0);
                check("run_nwe",     32'(BOOTSTRAP_N_WE), 32'h1);
            end
        end

        for (int k = 1; k <= 4; k++) begin
            tick();
            check("run_step", 32'(MC_ADDR), 32'(k));
        end

        MC_WORD = 32'hFFFD_1D95;
        #1;
        check("dec_ctrl",  32'(CTRL_DATA), 32'h15);
        check("dec_reg",   32'(REG_SEL),   32'h2);
        check("dec_out",   32'(OUT_PLANE), 32'h5);
        check("dec_in",    32'(IN_PLANE),  32'h3);
        check("dec_misc",  32'(MISC),      32'h0);
        check("dec_misc2", 32'(MISC2),     32'hA);
        tick();
        check("dec_step", 32'(MC_ADDR), 32'h005);

        MC_WORD = 32'h0;
        repeat (26) tick();
        check("cnt_31", 32'(MC_ADDR), 32'h01F);
        tick();
        check("cnt_wrap", 32'(MC_ADDR), 32'h000);

        // Opcode from OPWORD together with counter reset.
        OPWORD  = 32'h0800_0000;
        MC_WORD = mkword(6'h3F, 2'd0, 3'd0, 3'd6, 1'b1, 4'b1110);
        tick();
        check("opld_opword", 32'(MC_ADDR), 32'h040);

        MC_WORD = 32'h0;
        repeat (7) tick();
        check("cnt_7", 32'(MC_ADDR), 32'h047);

        // Opcode from CTRL_DATA, counter keeps incrementing.
        MC_WORD = mkword(6'h01, 2'd0, 3'd0, 3'd6, 1'b0, 4'b0001);
        #1;
        check("opld_in",   32'(IN_PLANE),  32'h6);
        check("opld_ctrl", 32'(CTRL_DATA), 32'h01);
        tick();
        check("opld_ctrl_addr", 32'(MC_ADDR), 32'h028);

        MC_WORD = mkword(6'h00, 2'd0, 3'd0, 3'd0, 1'b1, 4'b0000);
        tick();
        check("misc_reset", 32'(MC_ADDR), 32'h020);

        MC_WORD = mkword(6'h00, 2'd0, 3'd0, 3'd6, 1'b1, 4'b0000);
        tick();
        check("opld_again", 32'(MC_ADDR), 32'h040);
        MC_WORD = 32'h0;
        repeat (5) tick();
        check("pre_stall", 32'(MC_ADDR), 32'h045);

        // Stall with a word that would otherwise reset, reload and write.
        STALL      = 1'b1;
        BOOT_VALID = 1'b1;
        MC_WORD    = mkword(6'h3F, 2'd3, 3'd7, 3'd6, 1'b1, 4'hF);
        #1;
        check("stall_ctrl",  32'(CTRL_DATA), 32'h0);
        check("stall_reg",   32'(REG_SEL),   32'h0);
        check("stall_out",   32'(OUT_PLANE), 32'h0);
        check("stall_in",    32'(IN_PLANE),  32'h0);
        check("stall_misc",  32'(MISC),      32'h0);
        check("stall_misc2", 32'(MISC2),     32'h0);
        check("stall_ready", 32'(BOOT_READY), 32'h0);
        check("stall_nwe",   32'(BOOTSTRAP_N_WE), 32'h1);
        for (int s = 0; s < 3; s++) begin
            tick();
            check("stall_hold", 32'(MC_ADDR),  32'h045);
            check("stall_zero", 32'(IN_PLANE), 32'h0);
        end
        STALL   = 1'b0;
        MC_WORD = 32'h0;
        tick();
        check("stall_resume", 32'(MC_ADDR), 32'h046);

        // Reset in RUN dominates STALL and BOOT_VALID, and re-enters LOAD.
        RST     = 1'b1;
        STALL   = 1'b1;
        MC_WORD = 32'hFFFD_1D95;
        tick();
        check("rerst_mcaddr",  32'(MC_ADDR),        32'h0);
        check("rerst_nbooted", 32'(N_BOOTED),       32'h1);
        check("rerst_ready",   32'(BOOT_READY),     32'h1);
        check("rerst_nwe",     32'(BOOTSTRAP_N_WE), 32'h1);
        check("rerst_addr",    32'(BOOTSTRAP_ADDR), 32'h0);
        check("rerst_ctrl",    32'(CTRL_DATA),      32'h0);

        RST        = 1'b0;
        STALL      = 1'b0;
        BOOT_VALID = 1'b0;
        for (int w = 0; w < 3; w++) begin
            tick();
            check("idle_ready", 32'(BOOT_READY),     32'h1);
            check("idle_nwe",   32'(BOOTSTRAP_N_WE), 32'h1);
        end

        BOOT_VALID = 1'b1;
        BOOT_BYTE  = 8'h11;
        tick();
        BOOT_BYTE  = 8'h22;
        tick();
        tick();
        tick();
        check("part_addr",    32'(BOOTSTRAP_ADDR), 32'h2);
        check("part_nbooted", 32'(N_BOOTED),       32'h1);

        // Reset mid-load restarts at address 0.
        RST       = 1'b1;
        BOOT_BYTE = 8'h33;
        tick();
        check("midrst_addr",    32'(BOOTSTRAP_ADDR), 32'h0);
        check("midrst_data",    32'(BOOTSTRAP_DATA), 32'h0);
        check("midrst_nwe",     32'(BOOTSTRAP_N_WE), 32'h1);
        check("midrst_nbooted", 32'(N_BOOTED),       32'h1);
        RST = 1'b0;
        tick();
        check("reload_nwe",  32'(BOOTSTRAP_N_WE), 32'h0);
        check("reload_addr", 32'(BOOTSTRAP_ADDR), 32'h0);
        check("reload_data", 32'(BOOTSTRAP_DATA), 32'h33);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
